// File: rtl/dyn_pattern_multi_pkg.sv
// dyn_pattern_multi_pkg: shared defaults, mode encoding and width helpers
// for the multi-channel serial pattern detector.
package dyn_pattern_multi_pkg;

   localparam int MAX_BITS_DEF = 8;
   localparam int NUM_PAT_DEF  = 4;

   typedef enum logic {
      NON_OVERLAP = 1'b0,
      OVERLAP     = 1'b1
   } mode_e;

   // Channel index width, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width able to hold a length of 0..m.
   function automatic int len_w(input int m);
      return $clog2(m + 1);
   endfunction

   localparam int IDX_W_DEF = idx_w(NUM_PAT_DEF);
   localparam int LEN_W_DEF = len_w(MAX_BITS_DEF);

endpackage

// File: rtl/dyn_pattern_multi_chan.sv
// dyn_pattern_chan: one detector channel (stored pattern/len, fill counter,
// compare against the shared buffer, registered match).
// Ports: clk, rst, valid_i, mode_i, mode_chg_i, cfg_wr_i, cfg_pattern_i,
//        cfg_len_i, buf_i (buffer after this cycle's shift), match_d_o, match_o.
module dyn_pattern_chan
   import dyn_pattern_multi_pkg::*;
#(
   parameter int MAX_BITS = MAX_BITS_DEF,
   parameter int LEN_W    = len_w(MAX_BITS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  mode_e               mode_i,
   input  logic                mode_chg_i,
   input  logic                cfg_wr_i,
   input  logic [MAX_BITS-1:0] cfg_pattern_i,
   input  logic [LEN_W-1:0]    cfg_len_i,
   input  logic [MAX_BITS-1:0] buf_i,
   output logic                match_d_o,
   output logic                match_o
);

   logic [MAX_BITS-1:0] pat_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    fill_q, fill_d;
   logic                match_q;
   logic [MAX_BITS-1:0] mask;
   logic [LEN_W:0]      fill_p1;
   logic                en, full, hit;

   always_comb begin
      mask = '0;
      for (int b = 0; b < MAX_BITS; b++) begin
         mask[b] = (32'(len_q) > b);
      end
   end

   assign en      = (len_q != '0) && (32'(len_q) <= MAX_BITS);
   assign fill_p1 = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
   assign full    = (fill_p1 >= {1'b0, len_q});

   // A config write to this channel suppresses the coincident sample's match.
   assign hit = valid_i && !cfg_wr_i && en && full &&
                ((buf_i & mask) == (pat_q & mask));

   always_comb begin
      fill_d = fill_q;
      if (cfg_wr_i || mode_chg_i) begin
         fill_d = '0;
      end else if (valid_i) begin
         if (hit && (mode_i == NON_OVERLAP)) begin
            fill_d = '0;
         end else if (full) begin
            fill_d = len_q;
         end else begin
            fill_d = fill_p1[LEN_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         if (cfg_wr_i) begin
            pat_q <= cfg_pattern_i;
            len_q <= cfg_len_i;
         end
         fill_q  <= fill_d;
         match_q <= hit;
      end
   end

   assign match_d_o = hit;
   assign match_o   = match_q;

endmodule

// File: rtl/dyn_pattern_multi.sv
// dyn_pattern_multi: serial multi-pattern detector with shared shift buffer,
// per-channel configuration and a saturating match counter.
// Ports: clk, rst, valid, in, mode, cfg_we/cfg_idx/cfg_pattern/cfg_len,
//        cnt_clr -> match[NUM_PAT], match_any, match_count[CNT_W].
module dyn_pattern_multi
   import dyn_pattern_multi_pkg::*;
#(
   parameter int MAX_BITS = MAX_BITS_DEF,
   parameter int NUM_PAT  = NUM_PAT_DEF,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid,
   input  logic                        in,
   input  logic                        mode,
   input  logic                        cfg_we,
   input  logic [idx_w(NUM_PAT)-1:0]   cfg_idx,
   input  logic [MAX_BITS-1:0]         cfg_pattern,
   input  logic [len_w(MAX_BITS)-1:0]  cfg_len,
   input  logic                        cnt_clr,
   output logic [NUM_PAT-1:0]          match,
   output logic                        match_any,
   output logic [CNT_W-1:0]            match_count
);

   localparam int LEN_W = len_w(MAX_BITS);

   logic [MAX_BITS-1:0] buf_q, buf_d;
   mode_e               mode_q;
   logic                mode_chg;
   logic [NUM_PAT-1:0]  cfg_wr;
   logic [NUM_PAT-1:0]  match_d;
   logic                any_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign buf_d    = valid ? {buf_q[MAX_BITS-2:0], in} : buf_q;
   assign mode_chg = (mode_e'(mode) != mode_q);

   // Indices >= NUM_PAT decode to no channel, so such writes are dropped.
   always_comb begin
      cfg_wr = '0;
      for (int i = 0; i < NUM_PAT; i++) begin
         cfg_wr[i] = cfg_we && (32'(cfg_idx) == i);
      end
   end

   for (genvar g = 0; g < NUM_PAT; g++) begin : g_chan
      dyn_pattern_chan #(
         .MAX_BITS (MAX_BITS),
         .LEN_W    (LEN_W)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .valid_i       (valid),
         .mode_i        (mode_e'(mode)),
         .mode_chg_i    (mode_chg),
         .cfg_wr_i      (cfg_wr[g]),
         .cfg_pattern_i (cfg_pattern),
         .cfg_len_i     (cfg_len),
         .buf_i         (buf_d),
         .match_d_o     (match_d[g]),
         .match_o       (match[g])
      );
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if ((|match_d) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         mode_q <= NON_OVERLAP;
         any_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         buf_q  <= buf_d;
         mode_q <= mode_e'(mode);
         any_q  <= |match_d;
         cnt_q  <= cnt_d;
      end
   end

   assign match_any   = any_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_dyn_pattern_multi.sv
// tb_dyn_pattern_multi: scoreboard bench for dyn_pattern_multi; a second
// instance with a 4-bit counter shares all stimulus to exercise saturation.
module tb_dyn_pattern_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0, in = 1'b0, mode = 1'b0;
   logic       cfg_we = 1'b0, cnt_clr = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;

   logic [3:0]  match, match4;
   logic        any, any4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   typedef struct packed {
      logic [3:0]  m;
      logic [15:0] c;
      logic [3:0]  c4;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int unsigned ec = 0, ec4 = 0, c0;

   dyn_pattern_multi u_dut (
      .clk(clk), .rst(rst), .valid(valid), .in(in), .mode(mode),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cnt_clr(cnt_clr),
      .match(match), .match_any(any), .match_count(cnt)
   );

   dyn_pattern_multi #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .valid(valid), .in(in), .mode(mode),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cnt_clr(cnt_clr),
      .match(match4), .match_any(any4), .match_count(cnt4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic b, input logic we,
                       input logic [1:0] idx, input logic [7:0] pat,
                       input logic [3:0] len, input logic clr,
                       input logic [3:0] em);
      exp_t e;
      valid = v; in = b; cfg_we = we; cfg_idx = idx;
      cfg_pattern = pat; cfg_len = len; cnt_clr = clr;
      if (clr) begin
         ec = 0; ec4 = 0;
      end else if (em != 4'd0) begin
         if (ec < 65535) ec++;
         if (ec4 < 15) ec4++;
      end
      sb.push_back('{em, 16'(ec), 4'(ec4)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("match", 32'(match), 32'(e.m));
      chk("match_any", 32'(any), 32'(|e.m));
      chk("count", 32'(cnt), 32'(e.c));
      chk("match_sat", 32'(match4), 32'(e.m));
      chk("count_sat", 32'(cnt4), 32'(e.c4));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 1'b0, 4'd0);
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [7:0] pat,
                      input logic [3:0] len);
      step(1'b0, 1'b0, 1'b1, idx, pat, len, 1'b0, 4'd0);
   endtask

   task automatic bit_(input logic b, input logic [3:0] em);
      step(1'b1, b, 1'b0, 2'd0, 8'd0, 4'd0, 1'b0, em);
   endtask

   // bits/hits are MSB-first; hit positions expect match == chm.
   task automatic send(input logic [15:0] bits, input int n,
                       input logic [15:0] hits, input logic [3:0] chm);
      for (int i = n - 1; i >= 0; i--) begin
         bit_(bits[i], hits[i] ? chm : 4'd0);
      end
   endtask

   initial begin
      #1;
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_any", 32'(any), 32'd0);
      chk("rst_count", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Non-overlapping 10110 over 1011010110
      cfg(2'd0, 8'b10110, 4'd5);
      send(16'b1011010110, 10, 16'b0000100001, 4'b0001);
      chk("cnt_two", 32'(cnt), 32'd2);

      // 101 overlapping, then non-overlapping
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 1'b1, 4'd0);
      cfg(2'd0, 8'b101, 4'd3);
      mode = 1'b1;
      idle();
      send(16'b10101, 5, 16'b00101, 4'b0001);
      mode = 1'b0;
      idle();
      send(16'b10101, 5, 16'b00100, 4'b0001);

      // Two channels completing on the same bit
      mode = 1'b1;
      idle();
      cfg(2'd0, 8'b101, 4'd3);
      cfg(2'd1, 8'b0101, 4'd4);
      c0 = ec;
      send(16'b0101, 4, 16'b0001, 4'b0011);
      chk("cnt_plus_one", 32'(cnt), 32'(c0 + 1));
      cfg(2'd1, 8'd0, 4'd0);

      // Idle cycles between every bit
      mode = 1'b0;
      idle();
      cfg(2'd0, 8'b10110, 4'd5);
      bit_(1'b1, 4'd0); idle();
      bit_(1'b0, 4'd0); idle();
      bit_(1'b1, 4'd0); idle();
      bit_(1'b1, 4'd0); idle();
      bit_(1'b0, 4'd1); idle();

      // Reset mid-sequence
      send(16'b101, 3, 16'd0, 4'd0);
      valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_match", 32'(match), 32'd0);
      chk("rst_mid_any", 32'(any), 32'd0);
      chk("rst_mid_count", 32'(cnt), 32'd0);
      ec = 0; ec4 = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(16'b10110, 5, 16'd0, 4'd0);
      cfg(2'd0, 8'b10110, 4'd5);
      send(16'b10110, 5, 16'b00001, 4'b0001);

      // Config write on ch0 coincident with its completing bit
      cfg(2'd1, 8'b10, 4'd2);
      cfg(2'd0, 8'b10110, 4'd5);
      bit_(1'b1, 4'd0);
      bit_(1'b0, 4'b0010);
      bit_(1'b1, 4'd0);
      bit_(1'b1, 4'd0);
      step(1'b1, 1'b0, 1'b1, 2'd0, 8'b10110, 4'd5, 1'b0, 4'b0010);

      // Saturation and clear; ch2 has len 9 and must stay disabled
      mode = 1'b1;
      idle();
      cfg(2'd1, 8'd0, 4'd0);
      cfg(2'd2, 8'hFF, 4'd9);
      cfg(2'd0, 8'b1, 4'd1);
      repeat (20) bit_(1'b1, 4'b0001);
      chk("cnt4_sat", 32'(cnt4), 32'd15);
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'd0, 1'b1, 4'b0001);
      chk("cnt_clr_wins", 32'(cnt), 32'd0);
      bit_(1'b1, 4'b0001);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dyn_pattern_multi.md
DYN_PATTERN_MULTI -- requirements
Module: dyn_pattern_multi

Interface
REQ-001 Parameter MAX_BITS, default 8, maximum pattern length in bits (range 2..32).
REQ-002 Parameter NUM_PAT, default 4, number of independent pattern channels (range 1..8).
REQ-003 Parameter CNT_W, default 16, width of the match counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 valid  input  1  qualifies in as a serial sample this cycle.
REQ-007 in  input  1  serial data bit.
REQ-008 mode  input  1  0 = non-overlapping detection, 1 = overlapping detection.
REQ-009 cfg_we  input  1  configuration write strobe.
REQ-010 cfg_idx  input  clog2(NUM_PAT) (min 1)  channel being written.
REQ-011 cfg_pattern  input  MAX_BITS  pattern value, right-aligned (LSB = last bit received).
REQ-012 cfg_len  input  clog2(MAX_BITS+1)  pattern length in bits.
REQ-013 cnt_clr  input  1  synchronous clear of match_count.
REQ-014 match  output  NUM_PAT  per-channel one-cycle match pulse, registered.
REQ-015 match_any  output  1  registered OR of match.
REQ-016 match_count  output  CNT_W  saturating count of cycles with match_any high.

Function
REQ-017 On valid=1, a shared MAX_BITS shift buffer SHALL shift left with in entering the LSB; on valid=0, buffer, fill counters and configuration SHALL hold, except for configuration writes.
REQ-018 Each channel SHALL keep a fill counter, saturating at its len, that increments on every valid sample.
REQ-019 A channel SHALL be enabled only when its stored len is in 1..MAX_BITS; a write with len 0 or len > MAX_BITS SHALL store the write and disable the channel.
REQ-020 On a valid sample, match[i] SHALL be set at that same edge when channel i is enabled, (fill+1) >= len[i], and the low len[i] bits of the updated buffer equal the low len[i] bits of pattern[i]; otherwise match[i] SHALL be cleared.
REQ-021 Latency: match is visible in the cycle after the edge that samples the completing bit; each pulse lasts exactly one cycle, unless the next cycle's sample also matches.
REQ-022 match SHALL be 0 in any cycle following an edge with valid=0.
REQ-023 In mode 0, a match on channel i SHALL reset fill[i] to 0, so the next match needs len[i] fresh bits.
REQ-024 In mode 1, fill[i] SHALL remain saturated after a match, allowing matches on consecutive samples.
REQ-025 A change of mode between consecutive cycles SHALL clear all fill counters; the buffer SHALL be kept.
REQ-026 cfg_we=1 SHALL latch cfg_pattern and cfg_len into channel cfg_idx and clear fill[cfg_idx].
REQ-027 cfg_we=1 with cfg_idx >= NUM_PAT SHALL be ignored.
REQ-028 When cfg_we and valid coincide on channel i, the configuration write SHALL win: match[i]=0, fill[i]=0, the buffer still shifts, and other channels operate normally.
REQ-029 match_count SHALL increment by 1 per cycle in which match_any is set at the edge, saturate at all-ones, and never wrap.
REQ-030 cnt_clr SHALL zero match_count; when it coincides with an increment, cnt_clr wins.

Reset
REQ-031 rst=1 SHALL asynchronously clear the buffer, all fill counters, all patterns, all lens (all channels disabled), match, match_any and match_count.
REQ-032 rst asserted mid-sequence SHALL discard partial matches; after release, detection SHALL restart with empty fill counters.

Structure
REQ-033 A shared package SHALL hold the MAX_BITS/NUM_PAT defaults, the mode encodings (NON_OVERLAP=0, OVERLAP=1) and the clog2-derived width constants.
REQ-034 The per-channel compare/fill logic SHALL be one sub-module, dyn_pattern_chan, instantiated NUM_PAT times; the top level owns the buffer, the configuration decode and the counter.

Verification
REQ-035 Defaults; ch0 = 5'b10110 (len 5); mode 0; stream 1011010110 -> match[0] pulses after bits 5 and 10 only; match_count = 2.
REQ-036 Same as REQ-035 with ch0 = 3'b101 (len 3), mode 1, stream 10101 -> match[0] after bits 3 and 5; mode 0 with the same stream -> match[0] after bit 3 only.
REQ-037 ch0 = 101/len3 and ch1 = 0101/len4, mode 1, stream 0101 -> after bit 4, match = 4'b0011 and match_any=1; match_count increments by 1, not 2.
REQ-038 valid toggled low between each bit of 10110 (ch0 len 5) -> single match[0] after the fifth valid bit; match=0 on every idle cycle.
REQ-039 rst pulsed after 3 bits of 10110 (ch0 reprogrammed after reset), then 10110 sent -> no match until the fifth post-reset bit; also cfg_we on ch0 coincident with the completing bit -> match[0]=0.
REQ-040 CNT_W=4 with 17 matches -> match_count holds at 15; cnt_clr coincident with a match -> 0.
